// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish on the accept edge; MUL runs iteratively for WIDTH cycles.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flag
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned CW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
    OP_ADC = 4'h8, OP_SBB = 4'h9, OP_ASR = 4'hA, OP_ROL = 4'hB,
    OP_MUL = 4'hC
  } op_e;

  state_e             state, next_state;
  logic               cin;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;

  logic               accept;
  logic               is_mul;
  logic               last;
  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_next;

  assign accept = in_valid && in_ready;
  assign is_mul = (opcode == OP_MUL);
  assign last   = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = is_mul ? EXEC : DONE;
      EXEC: if (last)   next_state = DONE;
      DONE: begin
        if (accept)         next_state = is_mul ? EXEC : DONE;
        else if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  end

  // Single-cycle datapath
  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        ext     = {1'b0, A} + {1'b0, B} +
                  {{WIDTH{1'b0}}, (opcode == OP_ADC) ? cin : 1'b0};
        alu_res = ext[MSB:0];
        alu_c   = ext[WIDTH];
        alu_v   = (A[MSB] == B[MSB]) && (alu_res[MSB] != A[MSB]);
      end
      OP_SUB, OP_SBB: begin
        ext     = {1'b0, A} - {1'b0, B} -
                  {{WIDTH{1'b0}}, (opcode == OP_SBB) ? cin : 1'b0};
        alu_res = ext[MSB:0];
        alu_c   = ext[WIDTH];
        alu_v   = (A[MSB] != B[MSB]) && (alu_res[MSB] != A[MSB]);
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_NOT: alu_res = ~A;
      OP_SHL: begin
        alu_res = {A[MSB-1:0], 1'b0};
        alu_c   = A[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, A[MSB:1]};
        alu_c   = A[0];
      end
      OP_ASR: begin
        alu_res = {A[MSB], A[MSB:1]};
        alu_c   = A[0];
      end
      OP_ROL: begin
        alu_res = {A[MSB-1:0], A[MSB]};
        alu_c   = A[MSB];
      end
      default: ;
    endcase
  end

  // One shift-add step: multiplier sits in the low half and is consumed LSB first
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign acc_next = {mul_sum, acc[MSB:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
      flag      <= '0;
      cin       <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
    end else begin
      out_valid <= (next_state == DONE);
      if (accept) begin
        if (is_mul) begin
          acc   <= {{WIDTH{1'b0}}, B};
          mcand <= A;
          cnt   <= '0;
        end else begin
          res  <= alu_res;
          flag <= {alu_res[MSB], alu_v, (alu_res == '0), alu_c};
          cin  <= alu_c;
        end
      end else if (state == EXEC) begin
        acc <= acc_next;
        cnt <= cnt + CW'(1);
        if (last) begin
          res  <= acc_next[MSB:0];
          flag <= {acc_next[MSB], 1'b0, (acc_next[MSB:0] == '0),
                   |acc_next[2*WIDTH-1:WIDTH]};
          cin  <= |acc_next[2*WIDTH-1:WIDTH];
          cnt  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus random ops against an
// arithmetic reference model.
module tb_seq_alu;

  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic [3:0]   flag;

  int checks = 0;
  int errors = 0;
  int mcin   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flag      (flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int signed_of(input int v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  // Reference model from the arithmetic definitions of each opcode
  function automatic void model(input int op, input int a, input int b, input int c_in,
                                output int r, output int f, output int c, output int lat);
    int s, sv, v;
    s = 0; sv = 0; v = 0; c = 0; r = 0; lat = 0;
    case (op)
      0, 8: begin
        s  = a + b + ((op == 8) ? c_in : 0);
        sv = signed_of(a) + signed_of(b) + ((op == 8) ? c_in : 0);
        r  = s % M;
        c  = (s >= M) ? 1 : 0;
        v  = (sv > M / 2 - 1 || sv < -(M / 2)) ? 1 : 0;
      end
      1, 9: begin
        s  = a - b - ((op == 9) ? c_in : 0);
        sv = signed_of(a) - signed_of(b) - ((op == 9) ? c_in : 0);
        r  = (s + M) % M;
        c  = (s < 0) ? 1 : 0;
        v  = (sv > M / 2 - 1 || sv < -(M / 2)) ? 1 : 0;
      end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = M - 1 - a;
      6:  begin r = (a * 2) % M; c = (a >= M / 2) ? 1 : 0; end
      7:  begin r = a / 2; c = a % 2; end
      10: begin r = a / 2 + ((a >= M / 2) ? M / 2 : 0); c = a % 2; end
      11: begin r = (a * 2) % M + ((a >= M / 2) ? 1 : 0); c = (a >= M / 2) ? 1 : 0; end
      12: begin s = a * b; r = s % M; c = (s >= M) ? 1 : 0; lat = W; end
      default: r = 0;
    endcase
    f = ((r >= M / 2) ? 8 : 0) + v * 4 + ((r == 0) ? 2 : 0) + c;
  endfunction

  // Entered and left at a negedge; hold = cycles of out_ready low after the result
  task automatic run_op(input int op, input int a, input int b, input int hold,
                        input logic junk, input string tag);
    int er, ef, ec, el, lat;
    model(op, a, b, mcin, er, ef, ec, el);
    opcode   = 4'(op);
    A        = W'(a);
    B        = W'(b);
    in_valid = 1'b1;
    check({tag, " in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 3 * W) begin
      check({tag, " exec_ready"}, in_ready, 0);
      if (junk) begin
        in_valid = 1'b1;
        opcode   = 4'($urandom_range(0, 15));
        A        = W'($urandom);
        B        = W'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " latency"}, lat, el);
    check({tag, " res"}, res, er);
    check({tag, " flag"}, flag, ef);
    mcin = ec;
    if (hold > 0) begin
      out_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        check({tag, " hold_valid"}, out_valid, 1);
        check({tag, " hold_res"}, res, er);
        check({tag, " hold_flag"}, flag, ef);
        check({tag, " hold_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, " retired"}, out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int er, ef, ec, el;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    opcode    = '0;
    repeat (2) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset res", res, 0);
    check("reset flag", flag, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", in_ready, 1);

    // Directed arithmetic cases
    run_op(0, 8'hFF, 8'h01, 0, 1'b0, "add_ff_01");
    check("add_ff_01 const res", res, 0);
    run_op(1, 8'h80, 8'h01, 0, 1'b0, "sub_80_01");
    run_op(1, 8'h00, 8'h01, 0, 1'b0, "sub_00_01");
    run_op(12, 8'h0F, 8'h11, 0, 1'b1, "mul_0f_11");
    run_op(12, 8'h10, 8'h10, 0, 1'b0, "mul_10_10");
    run_op(0, 8'hFF, 8'h01, 0, 1'b0, "add_carry");
    run_op(8, 8'h01, 8'h01, 0, 1'b0, "adc_01_01");
    run_op(14, 8'h5A, 8'hA5, 0, 1'b0, "illegal_e");

    // Backpressure, then retire and accept on the same edge
    model(0, 8'h12, 8'h34, mcin, er, ef, ec, el);
    opcode = 4'h0; A = 8'h12; B = 8'h34; in_valid = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp add res", res, er);
    mcin = ec;
    repeat (5) begin
      @(negedge clk);
      check("bp stable res", res, er);
      check("bp stable flag", flag, ef);
      check("bp in_ready", in_ready, 0);
    end
    opcode = 4'h4; A = 8'hF0; B = 8'h3C; in_valid = 1'b1;
    @(negedge clk);
    check("bp queued res", res, er);
    check("bp queued ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp release ready", in_ready, 1);
    model(4, 8'hF0, 8'h3C, mcin, er, ef, ec, el);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp xor valid", out_valid, 1);
    check("bp xor res", res, er);
    check("bp xor flag", flag, ef);
    mcin = ec;
    @(negedge clk);
    check("bp xor retired", out_valid, 0);

    // Random ops with occasional backpressure and junk requests during EXEC
    for (int i = 0; i < 60; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, M - 1)),
             int'($urandom_range(0, M - 1)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
             1'($urandom_range(0, 1)), "random");
    end

    // Reset in the third EXEC cycle of a multiply
    run_op(0, 8'h05, 8'h06, 0, 1'b0, "pre_rst_add");
    opcode = 4'hC; A = 8'h0F; B = 8'h11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst out_valid", out_valid, 0);
    check("mid_rst in_ready", in_ready, 1);
    check("mid_rst res", res, 0);
    check("mid_rst flag", flag, 0);
    mcin = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("mid_rst no output", out_valid, 0);
    end
    run_op(8, 8'h01, 8'h01, 0, 1'b0, "adc_after_rst");
    check("adc_after_rst const res", res, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
